// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table, decode helper and the
// decoder's state/slot types.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] hex_t;

  localparam int NUM_DIGITS = 8;

  // Active-high gfedcba patterns for 0..F; the display driver uses the same table.
  localparam seg_t SEG_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic known;
    logic blank;
    hex_t value;
  } dec_t;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_ONE,
    SLOT_MULTI
  } slot_kind_t;

  typedef struct packed {
    slot_kind_t kind;
    logic [2:0] idx;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  function automatic dec_t seg_decode(input seg_t seg);
    dec_t d;
    d.known = 1'b0;
    d.blank = (seg == 7'h00);
    d.value = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        d.known = 1'b1;
        d.value = hex_t'(i);
      end
    end
    return d;
  endfunction

  function automatic slot_t an_classify(input logic [NUM_DIGITS-1:0] an_n);
    slot_t       s;
    int unsigned lows;
    s.kind = SLOT_NONE;
    s.idx  = '0;
    lows   = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!an_n[k]) begin
        lows  = lows + 1;
        s.idx = 3'(k);
      end
    end
    if (lows == 1)
      s.kind = SLOT_ONE;
    else if (lows > 1)
      s.kind = SLOT_MULTI;
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Bundle of the scanned display lines and the decoder's results.
interface seg7_scan_decoder_if;
  import seg7_pkg::*;

  seg_t        seg_i;
  logic [7:0]  an_n_i;
  logic        clr_err_i;
  logic [31:0] digits_o;
  logic [7:0]  known_o;
  logic [7:0]  blank_o;
  logic        frame_valid_o;
  logic        anode_err_o;

  modport master (
    output seg_i, an_n_i, clr_err_i,
    input  digits_o, known_o, blank_o, frame_valid_o, anode_err_o
  );

  modport slave (
    input  seg_i, an_n_i, clr_err_i,
    output digits_o, known_o, blank_o, frame_valid_o, anode_err_o
  );

endinterface

// File: rtl/seg7_sync.sv
// Multi-flop synchroniser for the raw anode/segment lines; depth 0 is a
// straight wire.
module seg7_sync #(
  parameter int         SYNC_STAGES = 2,
  parameter int         W           = 15,
  parameter logic [W-1:0] RST_VAL   = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign q = d;
    end else begin : g_chain
      logic [W-1:0] stage_p [SYNC_STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            stage_p[i] <= RST_VAL;
        end else begin
          stage_p[0] <= d;
          for (int i = 1; i < SYNC_STAGES; i++)
            stage_p[i] <= stage_p[i-1];
        end
      end

      assign q = stage_p[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 8-digit seven-segment display and recovers the hex
// value shown on each digit, flagging complete frames and anode conflicts.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_decoder_if.slave bus
);

  localparam int STABLE = (STABLE_CYC < 1) ? 1 : STABLE_CYC;
  localparam int CNT_W  = $clog2(STABLE + 1);

  // Anodes idle high out of reset so the first samples never look like a conflict.
  localparam logic [14:0] SYNC_RST = {8'hFF, 7'h00};

  logic [14:0] raw_lines;
  logic [14:0] sync_lines;
  seg_t        s_seg;
  logic [7:0]  s_an;
  slot_t       slot;
  logic        same;
  logic        is_multi;

  state_t      state;
  state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic        load;

  logic [2:0]  lat_idx;
  seg_t        lat_seg;

  logic [CNT_W-1:0] conf_cnt;
  logic [CNT_W-1:0] conf_nx;
  logic        err_set;

  logic [31:0] digits;
  logic [7:0]  known;
  logic [7:0]  blank;
  logic [7:0]  mask;
  logic [7:0]  mask_set;
  logic        frame_valid;
  logic        anode_err;
  dec_t        dec;

  assign raw_lines = {bus.an_n_i, bus.seg_i};

  seg7_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (15),
    .RST_VAL     (SYNC_RST)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_lines),
    .q     (sync_lines)
  );

  assign s_an     = sync_lines[14:7];
  assign s_seg    = SEG_ACTIVE_LOW ? ~sync_lines[6:0] : sync_lines[6:0];
  assign slot     = an_classify(s_an);
  assign is_multi = (slot.kind == SLOT_MULTI);
  assign same     = (slot.kind == SLOT_ONE) && (slot.idx == lat_idx) && (s_seg == lat_seg);

  // Dwell tracking: a slot must repeat unchanged STABLE times before capture.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot.kind == SLOT_ONE) begin
          load     = 1'b1;
          cnt_nx   = CNT_W'(1);
          state_nx = (STABLE == 1) ? ST_CAPTURE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (slot.kind != SLOT_ONE) begin
          state_nx = ST_IDLE;
        end else if (same) begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt_nx >= CNT_W'(STABLE))
            state_nx = ST_CAPTURE;
        end else begin
          load   = 1'b1;
          cnt_nx = CNT_W'(1);
          if (STABLE == 1)
            state_nx = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (!same)
          state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    conf_nx = '0;
    if (is_multi)
      conf_nx = (conf_cnt < CNT_W'(STABLE)) ? conf_cnt + CNT_W'(1) : conf_cnt;
  end

  assign err_set  = is_multi && (conf_nx == CNT_W'(STABLE));
  assign dec      = seg_decode(lat_seg);
  assign mask_set = mask | (8'h01 << lat_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      conf_cnt    <= '0;
      mask        <= '0;
      digits      <= '0;
      known       <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      conf_cnt    <= conf_nx;
      frame_valid <= 1'b0;
      if (state == ST_CAPTURE) begin
        digits[{lat_idx, 2'b00} +: 4] <= dec.value;
        known[lat_idx]                <= dec.known;
        blank[lat_idx]                <= dec.blank;
        if (mask_set == 8'hFF) begin
          frame_valid <= 1'b1;
          mask        <= '0;
        end else begin
          mask <= mask_set;
        end
      end
      // A fresh conflict outranks a clear arriving in the same cycle.
      if (err_set)
        anode_err <= 1'b1;
      else if (bus.clr_err_i)
        anode_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      lat_idx <= slot.idx;
      lat_seg <= s_seg;
    end
  end

  assign bus.digits_o      = digits;
  assign bus.known_o       = known;
  assign bus.blank_o       = blank;
  assign bus.frame_valid_o = frame_valid;
  assign bus.anode_err_o   = anode_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus a randomized scan
// stream checked against a dwell-level reference model.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_decoder_if bus_a ();
  seg7_scan_decoder_if bus_b ();

  seg7_scan_decoder #(
    .STABLE_CYC     (STABLE),
    .SYNC_STAGES    (SYNC),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  seg7_scan_decoder #(
    .STABLE_CYC     (STABLE),
    .SYNC_STAGES    (SYNC),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int frames_a = 0;
  int frames_b = 0;

  always @(negedge clk) begin
    if (bus_a.frame_valid_o === 1'b1) frames_a++;
    if (bus_b.frame_valid_o === 1'b1) frames_b++;
  end

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference state: what each digit should show and the frame bookkeeping.
  int unsigned m_val [8];
  logic [7:0]  m_known;
  logic [7:0]  m_blank;
  logic [7:0]  m_mask;
  int          m_frames;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_a(input logic [7:0] an, input logic [6:0] seg, input int cycles,
                        input int clr_at = -1);
    for (int c = 0; c < cycles; c++) begin
      bus_a.an_n_i    = an;
      bus_a.seg_i     = seg;
      bus_a.clr_err_i = (c == clr_at);
      @(posedge clk);
      #1;
    end
    bus_a.clr_err_i = 1'b0;
  endtask

  task automatic step_b(input logic [7:0] an, input logic [6:0] seg, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bus_b.an_n_i = an;
      bus_b.seg_i  = seg;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] model_digits();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*4 +: 4] = 4'(m_val[k]);
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_val[k] = 0;
    m_known  = '0;
    m_blank  = '0;
    m_mask   = '0;
    m_frames = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_capture(input int idx, input logic [6:0] seg);
    m_val[idx]   = 0;
    m_known[idx] = 1'b0;
    m_blank[idx] = (seg == 7'h00);
    for (int g = 0; g < 16; g++) begin
      if (glyph[g] == seg) begin
        m_val[idx]   = g;
        m_known[idx] = 1'b1;
      end
    end
    m_mask[idx] = 1'b1;
    if (m_mask == 8'hFF) begin
      m_frames++;
      m_mask = '0;
    end
  endtask

  initial begin
    int          scan_v [8] = '{7, 15, 0, 1, 10, 11, 13, 14};
    int          base;
    int          kind;
    int          len;
    int          clr_at;
    int          idx;
    int          a;
    int          b;
    logic [7:0]  an;
    logic [7:0]  prev_an;
    logic [6:0]  seg;
    logic [6:0]  prev_seg;
    logic        prev_conf;
    logic        saw8;

    bus_a.an_n_i = 8'hFF; bus_a.seg_i = 7'h00; bus_a.clr_err_i = 1'b0;
    bus_b.an_n_i = 8'hFF; bus_b.seg_i = 7'h7F; bus_b.clr_err_i = 1'b0;

    // Reset held while the lines toggle
    for (int i = 0; i < 5; i++) begin
      bus_a.an_n_i = 8'($urandom);
      bus_a.seg_i  = 7'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_digits", bus_a.digits_o, 32'h0);
    chk("rst_known", 32'(bus_a.known_o), 32'h0);
    chk("rst_blank", 32'(bus_a.blank_o), 32'h0);
    chk("rst_frame", 32'(bus_a.frame_valid_o), 32'h0);
    chk("rst_err", 32'(bus_a.anode_err_o), 32'h0);
    bus_a.an_n_i = 8'hFF;
    bus_a.seg_i  = 7'h00;
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    // First capture latency: SYNC + STABLE + 1 cycles
    bus_a.an_n_i = 8'hFE;
    bus_a.seg_i  = 7'h5B;
    for (int c = 0; c < SYNC + STABLE; c++) begin
      @(posedge clk);
      #1;
    end
    chk("lat_early", 32'(bus_a.digits_o[3:0]), 32'h0);
    @(posedge clk);
    #1;
    chk("lat_digit0", 32'(bus_a.digits_o[3:0]), 32'h2);
    chk("lat_known0", 32'(bus_a.known_o[0]), 32'h1);

    // Full scan of eight digits
    base = frames_a;
    for (int d = 0; d < 8; d++) begin
      an = 8'hFF ^ (8'h01 << d);
      step_a(an, glyph[scan_v[d]], 10);
    end
    step_a(8'hFF, 7'h00, 4);
    chk("scan_frames", 32'(frames_a - base), 32'h1);
    chk("scan_digits", bus_a.digits_o, 32'hEDBA10F7);
    chk("scan_known", 32'(bus_a.known_o), 32'hFF);
    chk("scan_blank", 32'(bus_a.blank_o), 32'h0);

    // Short 8 glitch ahead of a steady 1 on digit 3
    saw8 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus_a.an_n_i = (c < 8) ? 8'hF7 : 8'hFF;
      bus_a.seg_i  = (c < 2) ? 7'h7F : 7'h06;
      @(posedge clk);
      #1;
      if (bus_a.digits_o[15:12] == 4'h8) saw8 = 1'b1;
    end
    chk("glitch_never8", 32'(saw8), 32'h0);
    chk("glitch_digit3", 32'(bus_a.digits_o[15:12]), 32'h1);

    // Anode conflicts
    base = frames_a;
    step_a(8'hFC, 7'h06, STABLE - 1);
    step_a(8'hFF, 7'h00, 4);
    chk("conf_short", 32'(bus_a.anode_err_o), 32'h0);
    step_a(8'hFC, 7'h06, 8);
    chk("conf_err", 32'(bus_a.anode_err_o), 32'h1);
    chk("conf_digits", bus_a.digits_o, 32'hEDBA10F7);
    step_a(8'hFC, 7'h06, 3, 1);
    chk("conf_clr_lose", 32'(bus_a.anode_err_o), 32'h1);
    step_a(8'hFF, 7'h00, 6, 4);
    chk("conf_clr", 32'(bus_a.anode_err_o), 32'h0);
    chk("conf_frames", 32'(frames_a - base), 32'h0);

    // Blank and unrecognised patterns
    step_a(8'hDF, 7'h00, 10);
    step_a(8'hBF, 7'h01, 10);
    step_a(8'hFF, 7'h00, 4);
    chk("blank5", 32'(bus_a.blank_o[5]), 32'h1);
    chk("known5", 32'(bus_a.known_o[5]), 32'h0);
    chk("blank6", 32'(bus_a.blank_o[6]), 32'h0);
    chk("known6", 32'(bus_a.known_o[6]), 32'h0);
    chk("unk_digits", bus_a.digits_o, 32'hE00A10F7);

    // Randomized scan stream against the model
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    model_reset();
    base      = frames_a;
    prev_an   = 8'hFF;
    prev_seg  = 7'h00;
    prev_conf = 1'b0;
    for (int s = 0; s < 70; s++) begin
      kind   = $urandom_range(0, 9);
      clr_at = -1;
      if (prev_conf && kind >= 8) kind = 6;
      if (kind <= 5) begin
        idx = $urandom_range(0, 7);
        an  = 8'hFF ^ (8'h01 << idx);
        a   = $urandom_range(0, 9);
        if (a < 7)       seg = glyph[$urandom_range(0, 15)];
        else if (a == 7) seg = 7'h00;
        else             seg = 7'($urandom);
        if (an == prev_an && seg == prev_seg) seg = seg ^ 7'h01;
        len = (kind <= 3) ? $urandom_range(10, 14) : $urandom_range(1, STABLE - 1);
        step_a(an, seg, len);
        if (kind <= 3) model_capture(idx, seg);
        prev_conf = 1'b0;
      end else if (kind <= 7) begin
        an  = 8'hFF;
        seg = 7'($urandom);
        len = $urandom_range(1, 8);
        if (len >= 5 && $urandom_range(0, 1) == 1) begin
          clr_at = len - 2;
          m_err  = 1'b0;
        end
        step_a(an, seg, len, clr_at);
        prev_conf = 1'b0;
      end else begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        an  = 8'($urandom) & ~((8'h01 << a) | (8'h01 << b));
        seg = 7'($urandom);
        len = (kind == 8) ? $urandom_range(10, 12) : $urandom_range(1, STABLE - 1);
        step_a(an, seg, len);
        if (kind == 8) m_err = 1'b1;
        prev_conf = 1'b1;
      end
      prev_an  = an;
      prev_seg = seg;
      chk("rnd_digits", bus_a.digits_o, model_digits());
      chk("rnd_known", 32'(bus_a.known_o), 32'(m_known));
      chk("rnd_blank", 32'(bus_a.blank_o), 32'(m_blank));
      chk("rnd_err", 32'(bus_a.anode_err_o), 32'(m_err));
      chk("rnd_frames", 32'(frames_a - base), 32'(m_frames));
    end

    // Active-low segment instance
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    step_b(8'hFE, 7'h40, 10);
    step_b(8'hFF, 7'h7F, 3);
    chk("al_digit0", 32'(bus_b.digits_o[3:0]), 32'h0);
    chk("al_known0", 32'(bus_b.known_o[0]), 32'h1);
    chk("al_blank0", 32'(bus_b.blank_o[0]), 32'h0);

    // Reset arriving mid-settle
    step_b(8'hFD, ~glyph[2], 4);
    rst_b = 1'b1;
    step_b(8'hFD, ~glyph[2], 2);
    bus_b.an_n_i = 8'hFF;
    bus_b.seg_i  = 7'h7F;
    rst_b = 1'b0;
    step_b(8'hFF, 7'h7F, 8);
    chk("al_rst_digits", bus_b.digits_o, 32'h0);
    chk("al_rst_known", 32'(bus_b.known_o), 32'h0);

    base = frames_b;
    for (int d = 1; d < 8; d++) begin
      an = 8'hFF ^ (8'h01 << d);
      step_b(an, ~glyph[d], 10);
    end
    chk("al_mask_partial", 32'(frames_b - base), 32'h0);
    step_b(8'hFE, ~glyph[0], 10);
    step_b(8'hFF, 7'h7F, 4);
    chk("al_mask_frame", 32'(frames_b - base), 32'h1);
    chk("al_digits", bus_b.digits_o, 32'h76543210);
    chk("al_known", 32'(bus_b.known_o), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
